cart_bus_master: RTL and testbench
==================================

# cart_bus_master

Host-side initiator for the cartridge bus, the counterpart of the cartridge-side mapper (MBC) chip. It accepts single-byte read/write requests from the CPU side and sequences a complete cartridge bus cycle. Each cycle has a setup phase (address and chip select valid), a strobe phase (read or write asserted), and a hold phase (address, data and chip select stable after the strobe drops). It also generates a stretched cartridge reset after power-up.

## Interface
Parameters:
- SETUP_CYCLES, 1: clk cycles from address/cs valid to strobe assertion; ≥1.
- STROBE_CYCLES, 2: clk cycles read/write stay asserted; ≥1.
- HOLD_CYCLES, 1: clk cycles address/data/cs stay valid after strobe drops; ≥1.
- RESET_CYCLES, 4: clk cycles cart_reset stays high after nreset releases; ≥1.

Ports:
- clk  in  1  single clock; all state on posedge.
- nreset  in  1  asynchronous, active-low reset.
- req  in  1  request level, sampled only when accepting.
- we  in  1  1 = write, 0 = read; captured at accept.
- addr  in  16  CPU address; captured at accept.
- wdata  in  8  write data; captured at accept.
- busy  out  1  high when a request cannot be accepted.
- ack  out  1  one-cycle pulse at transaction end.
- rdata  out  8  read result; valid from ack, held until the next read's ack.
- cart_reset  out  1  active-high reset to the cartridge.
- cs_rom  out  1  asserted for 0x0000–0x7fff.
- cs_ram  out  1  asserted for 0xa000–0xfdff.
- adr  out  15  addr[14:0] of the current transaction.
- dout  out  8  write data driven to the cartridge.
- dout_oe  out  1  data-bus output enable.
- din  in  8  data from the cartridge.
- read  out  1  active-high read strobe.
- write  out  1  active-high write strobe; the cartridge latches on its falling edge.

## Operation
- FSM states: RST, IDLE, SETUP, STROBE, HOLD.
- RST: entered asynchronously while nreset=0; stays for RESET_CYCLES clocks after release; cart_reset=1 and busy=1 throughout; then goes to IDLE.
- IDLE: busy=0 and all strobes, cs and dout_oe are 0.
  - If req=1, capture we/addr/wdata, decode cs, and go to SETUP.
  - If req=0, stay in IDLE.
- SETUP: busy=1; adr and cs valid; dout_oe=we; dout=wdata. Lasts SETUP_CYCLES, then STROBE.
- STROBE: read=!we, write=we. Lasts STROBE_CYCLES.
  - For reads, din is registered into rdata on the last STROBE cycle.
  - Then HOLD.
- HOLD: strobes 0; adr, cs, dout and dout_oe unchanged. Lasts HOLD_CYCLES.
  - ack=1 on the last HOLD cycle.
  - Then IDLE.
- Undecoded addresses (0x8000–0x9fff, 0xfe00–0xffff): the full cycle still runs with both cs=0. A read returns rdata=0xff; din is ignored.
- Only one of read/write is ever asserted. cs_rom and cs_ram are mutually exclusive.
- Phase counter width is $clog2 of the largest parameter plus 1. It reloads on each state entry, so no wrap-around is possible.

## Timing
- Reset values: busy=1, ack=0, rdata=0xff, cart_reset=1, cs_rom=0, cs_ram=0, adr=0, dout=0, dout_oe=0, read=0, write=0.
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: req sampled high in IDLE at edge k gives ack high in cycle k+SETUP+STROBE+HOLD. With the defaults, ack is high in cycle k+4.
- Back-to-back: after ack the FSM spends ≥1 cycle in IDLE with all cs and strobes 0 (bus turnaround). req held high starts the next transaction on that IDLE edge.
- req changes outside IDLE are ignored, as are addr/we/wdata changes mid-transaction.
- nreset asserted mid-transaction immediately clears all strobes, cs and dout_oe. No ack is produced, and rdata returns to 0xff.
- Write guarantee: dout is stable from SETUP start until after write falls plus HOLD_CYCLES. This ensures the cartridge, which samples one clk after write falls, sees valid data.

## Structure
- Shared package cart_bus_pkg holds:
  - the state enum;
  - region constants: ROM 0x0000–0x7fff, RAM 0xa000–0xfdff;
  - the open-bus value 0xff.
- Sub-module cart_bus_decode: combinational mapping addr[15:0] → {cs_rom, cs_ram}. Its output is registered at accept in the parent.

## Test plan
- Reset: release nreset → cart_reset=1 and busy=1 for exactly 4 cycles, then cart_reset=0 and busy=0; all other outputs hold their reset values.
- ROM read: addr=0x4123, din=0x5a → cs_rom=1 and adr=0x4123 during SETUP; read=1 for 2 cycles; ack 4 cycles after accept; rdata=0x5a.
- MBC write: addr=0x2000, wdata=0x03 → write high for 2 cycles; dout=0x03 with dout_oe=1 through the HOLD cycle after write falls; cs_rom=1.
- RAM read and undecoded read: 0xa010, din=0x77 → cs_ram=1, rdata=0x77. 0x9000 → no cs asserted, rdata=0xff.
- Back-to-back: req held high for 3 transactions → each ack followed by exactly one IDLE cycle with strobes and cs all 0.
- Mid-cycle reset: nreset=0 during STROBE of a write → write=0 and dout_oe=0 immediately; no ack; RST sequence replays.

Source files
------------

// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge bus initiator.
package cart_bus_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic rom;
        logic ram;
    } cs_sel_t;

    // ROM occupies 0x0000 up to ROM_HI; RAM spans RAM_LO..RAM_HI.
    localparam logic [15:0] ROM_HI   = 16'h7fff;
    localparam logic [15:0] RAM_LO   = 16'ha000;
    localparam logic [15:0] RAM_HI   = 16'hfdff;
    localparam logic [7:0]  OPEN_BUS = 8'hff;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cart_bus_master_if.sv
// CPU-side request port and cartridge-side bus pins of the initiator.
interface cart_bus_master_if;

    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        ack;
    logic [7:0]  rdata;
    logic        cart_reset;
    logic        cs_rom;
    logic        cs_ram;
    logic [14:0] adr;
    logic [7:0]  dout;
    logic        dout_oe;
    logic [7:0]  din;
    logic        read;
    logic        write;

    modport master (
        input  req, we, addr, wdata, din,
        output busy, ack, rdata, cart_reset, cs_rom, cs_ram, adr, dout, dout_oe, read, write
    );

    modport slave (
        output req, we, addr, wdata, din,
        input  busy, ack, rdata, cart_reset, cs_rom, cs_ram, adr, dout, dout_oe, read, write
    );

endinterface

// File: rtl/cart_bus_decode.sv
// Address to chip-select decode; gaps in the map leave both selects low.
module cart_bus_decode
    import cart_bus_pkg::*;
(
    input  logic [15:0] addr,
    output cs_sel_t     sel_c
);

    always_comb begin
        sel_c     = '0;
        sel_c.rom = (addr <= ROM_HI);
        sel_c.ram = (addr >= RAM_LO) && (addr <= RAM_HI);
    end

endmodule

// File: rtl/cart_bus_master.sv
// Cartridge bus initiator: stretched cart reset, then setup/strobe/hold
// sequencing of single-byte CPU reads and writes.
module cart_bus_master
    import cart_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned RESET_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              nreset,
    cart_bus_master_if.master bus
);

    localparam int unsigned MAX_CYC = max_u(max_u(SETUP_CYCLES, STROBE_CYCLES),
                                            max_u(HOLD_CYCLES, RESET_CYCLES));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LD  = CNT_W'(RESET_CYCLES - 1);

    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             cart_reset_q, cart_reset_d;
    logic             cs_rom_q, cs_rom_d;
    logic             cs_ram_q, cs_ram_d;
    logic [14:0]      adr_q, adr_d;
    logic [7:0]       dout_q, dout_d;
    logic             dout_oe_q, dout_oe_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic             phase_done;
    cs_sel_t          sel_c;

    cart_bus_decode u_decode (
        .addr  (bus.addr),
        .sel_c (sel_c)
    );

    // Next state plus next value of every output, so all outputs leave flops.
    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        cs_rom_d  = cs_rom_q;
        cs_ram_d  = cs_ram_q;
        adr_d     = adr_q;
        dout_d    = dout_q;
        dout_oe_d = dout_oe_q;
        phase_done = (cnt_q == '0);

        case (st_q)
            ST_RST: begin
                if (phase_done) st_d = ST_IDLE;
                else            cnt_d = cnt_q - CNT_W'(1);
            end
            ST_IDLE: begin
                if (bus.req) begin
                    st_d      = ST_SETUP;
                    cnt_d     = SETUP_LD;
                    we_d      = bus.we;
                    adr_d     = bus.addr[14:0];
                    dout_d    = bus.wdata;
                    cs_rom_d  = sel_c.rom;
                    cs_ram_d  = sel_c.ram;
                    dout_oe_d = bus.we;
                end
            end
            ST_SETUP: begin
                if (phase_done) begin
                    st_d  = ST_STROBE;
                    cnt_d = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (phase_done) begin
                    st_d  = ST_HOLD;
                    cnt_d = HOLD_LD;
                    // Undecoded reads float the bus; din is not trusted there.
                    if (!we_q) rdata_d = (cs_rom_q || cs_ram_q) ? bus.din : OPEN_BUS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (phase_done) begin
                    st_d      = ST_IDLE;
                    cs_rom_d  = 1'b0;
                    cs_ram_d  = 1'b0;
                    dout_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                st_d      = ST_RST;
                cnt_d     = RESET_LD;
                cs_rom_d  = 1'b0;
                cs_ram_d  = 1'b0;
                dout_oe_d = 1'b0;
            end
        endcase

        busy_d       = (st_d != ST_IDLE);
        cart_reset_d = (st_d == ST_RST);
        read_d       = (st_d == ST_STROBE) && !we_d;
        write_d      = (st_d == ST_STROBE) && we_d;
        ack_d        = (st_d == ST_HOLD) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            st_q         <= ST_RST;
            cnt_q        <= RESET_LD;
            we_q         <= 1'b0;
            busy_q       <= 1'b1;
            ack_q        <= 1'b0;
            rdata_q      <= OPEN_BUS;
            cart_reset_q <= 1'b1;
            cs_rom_q     <= 1'b0;
            cs_ram_q     <= 1'b0;
            adr_q        <= '0;
            dout_q       <= '0;
            dout_oe_q    <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            cart_reset_q <= cart_reset_d;
            cs_rom_q     <= cs_rom_d;
            cs_ram_q     <= cs_ram_d;
            adr_q        <= adr_d;
            dout_q       <= dout_d;
            dout_oe_q    <= dout_oe_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.ack        = ack_q;
    assign bus.rdata      = rdata_q;
    assign bus.cart_reset = cart_reset_q;
    assign bus.cs_rom     = cs_rom_q;
    assign bus.cs_ram     = cs_ram_q;
    assign bus.adr        = adr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_oe    = dout_oe_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;

endmodule

// File: tb/tb_cart_bus_master.sv
// Scoreboard bench for cart_bus_master: directed transactions queue their
// expected bus behaviour, a negedge monitor checks strobes and acks against it.
module tb_cart_bus_master;

    localparam int unsigned SETUP  = 1;
    localparam int unsigned STROBE = 2;
    localparam int unsigned HOLD   = 1;
    localparam int unsigned RSTC   = 4;
    localparam int          LAT    = SETUP + STROBE + HOLD;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic        rom;
        logic        ram;
        logic [7:0]  rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [14:0] adr;
        logic [7:0]  wdata;
        logic        rom;
        logic        ram;
        logic [7:0]  rdata;
        int          accept;
    } exp_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   strobe_cnt = 0;
    bit   turn_chk = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[14];

    cart_bus_master_if bus ();

    cart_bus_master #(
        .SETUP_CYCLES  (SETUP),
        .STROBE_CYCLES (STROBE),
        .HOLD_CYCLES   (HOLD),
        .RESET_CYCLES  (RSTC)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: strobe-phase and ack-phase comparisons against the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!nreset) begin
            strobe_cnt = 0;
            turn_chk   = 1'b0;
        end else begin
            if (turn_chk) begin
                check("turnaround_idle", 64'({bus.busy, bus.cs_rom, bus.cs_ram, bus.read, bus.write, bus.dout_oe}), 64'(0));
                turn_chk = 1'b0;
            end
            if (bus.read || bus.write) begin
                check("one_strobe", 64'(bus.read & bus.write), 64'(0));
                if (exp_q.size() == 0) begin
                    check("stray_strobe", 64'(1), 64'(0));
                end else begin
                    e = exp_q[0];
                    check("strobe_bus", 64'({bus.read, bus.write, bus.cs_rom, bus.cs_ram, bus.adr, bus.dout_oe}),
                          64'({~e.we, e.we, e.rom, e.ram, e.adr, e.we}));
                    if (e.we) check("strobe_dout", 64'(bus.dout), 64'(e.wdata));
                    strobe_cnt++;
                end
            end
            if (bus.ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("ack_latency", 64'(cyc + 1 - e.accept), 64'(LAT));
                    check("strobe_len", 64'(strobe_cnt), 64'(STROBE));
                    check("rdata", 64'(bus.rdata), 64'(e.rdata));
                    check("hold_bus", 64'({bus.read, bus.write, bus.cs_rom, bus.cs_ram, bus.adr, bus.dout_oe}),
                          64'({1'b0, 1'b0, e.rom, e.ram, e.adr, e.we}));
                    if (e.we) check("hold_dout", 64'(bus.dout), 64'(e.wdata));
                end
                strobe_cnt = 0;
                turn_chk   = 1'b1;
            end
        end
    end

    task automatic issue(input int idx, input int acc);
        vec_t v;
        exp_t e;
        v = vecs[idx];
        bus.req   = 1'b1;
        bus.we    = v.we;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        bus.din   = v.din;
        e.we     = v.we;
        e.adr    = v.addr[14:0];
        e.wdata  = v.wdata;
        e.rom    = v.rom;
        e.ram    = v.ram;
        e.rdata  = v.rdata;
        e.accept = acc;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = !bus.busy;
        end
        check("idle_reached", 64'(seen), 64'(1));
    endtask

    task automatic wait_ack();
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = bus.ack;
        end
        check("ack_reached", 64'(seen), 64'(1));
    endtask

    // Single transaction; request inputs are scrambled right after accept.
    task automatic single(input int idx);
        wait_idle();
        issue(idx, cyc + 1);
        @(posedge clk);
        #1;
        bus.req   = 1'b0;
        bus.we    = ~bus.we;
        bus.addr  = ~bus.addr;
        bus.wdata = ~bus.wdata;
        wait_ack();
    endtask

    // Release reset just after an edge and watch the stretched cart reset.
    task automatic reset_seq();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("cart_reset_seq", 64'(bus.cart_reset), 64'(i < 4));
            check("busy_seq", 64'(bus.busy), 64'(i < 4));
            if (i == 0)
                check("reset_values",
                      64'({bus.ack, bus.rdata, bus.cs_rom, bus.cs_ram, bus.adr, bus.dout, bus.dout_oe, bus.read, bus.write}),
                      64'({1'b0, 8'hff, 1'b0, 1'b0, 15'h0, 8'h00, 1'b0, 1'b0, 1'b0}));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        // we, addr, wdata, din, cs_rom, cs_ram, rdata expected after ack
        vecs = '{
            '{1'b0, 16'h4123, 8'h00, 8'h5a, 1'b1, 1'b0, 8'h5a},
            '{1'b1, 16'h2000, 8'h03, 8'h00, 1'b1, 1'b0, 8'h5a},
            '{1'b0, 16'ha010, 8'h00, 8'h77, 1'b0, 1'b1, 8'h77},
            '{1'b0, 16'h9000, 8'h00, 8'h33, 1'b0, 1'b0, 8'hff},
            '{1'b1, 16'hfe10, 8'hc3, 8'h00, 1'b0, 1'b0, 8'hff},
            '{1'b0, 16'h7fff, 8'h00, 8'h81, 1'b1, 1'b0, 8'h81},
            '{1'b0, 16'hfdff, 8'h00, 8'h42, 1'b0, 1'b1, 8'h42},
            '{1'b0, 16'hfe00, 8'h00, 8'h11, 1'b0, 1'b0, 8'hff},
            '{1'b0, 16'h8000, 8'h00, 8'h22, 1'b0, 1'b0, 8'hff},
            '{1'b0, 16'h0100, 8'h00, 8'ha5, 1'b1, 1'b0, 8'ha5},
            '{1'b1, 16'hc000, 8'h5e, 8'h00, 1'b0, 1'b1, 8'ha5},
            '{1'b0, 16'ha000, 8'h00, 8'h9c, 1'b0, 1'b1, 8'h9c},
            '{1'b1, 16'h3000, 8'h99, 8'h00, 1'b1, 1'b0, 8'h9c},
            '{1'b0, 16'h1234, 8'h00, 8'h4e, 1'b1, 1'b0, 8'h4e}
        };
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 16'h0;
        bus.wdata = 8'h0;
        bus.din   = 8'h0;
        repeat (2) @(posedge clk);
        reset_seq();

        for (int i = 0; i < 9; i++) single(i);

        // Back-to-back with req held high: next accept two edges after each ack.
        wait_idle();
        issue(9, cyc + 1);
        for (int j = 10; j < 12; j++) begin
            wait_ack();
            issue(j, cyc + 2);
        end
        wait_ack();
        bus.req = 1'b0;

        // Abort a write in its strobe phase with reset.
        wait_idle();
        issue(12, cyc + 1);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = bus.write;
        end
        check("abort_write_seen", 64'(seen), 64'(1));
        nreset = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("abort_clear",
              64'({bus.write, bus.read, bus.dout_oe, bus.cs_rom, bus.cs_ram, bus.ack, bus.rdata, bus.cart_reset, bus.busy}),
              64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hff, 1'b1, 1'b1}));
        repeat (2) @(negedge clk);
        reset_seq();

        single(13);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
